// File: rtl/i2c_master_ack_checker_if.sv
// Control-side handshake between the I2C master FSM and the ACK checker.
// slave: the checker's view; master: the control FSM's view.
interface i2c_master_ack_checker_if #(
    parameter int unsigned RETRY_MAX = 3
);
    localparam int unsigned CntW = $clog2(RETRY_MAX + 1);

    logic            enable;
    logic            clear_retry;
    logic            busy;
    logic            ack_valid;
    logic            ack;
    logic            bus_err;
    logic            timeout;
    logic [CntW-1:0] nack_cnt;
    logic            nack_limit;

    modport master (
        output enable,
        output clear_retry,
        input  busy,
        input  ack_valid,
        input  ack,
        input  bus_err,
        input  timeout,
        input  nack_cnt,
        input  nack_limit
    );

    modport slave (
        input  enable,
        input  clear_retry,
        output busy,
        output ack_valid,
        output ack,
        output bus_err,
        output timeout,
        output nack_cnt,
        output nack_limit
    );
endinterface

// File: rtl/i2c_master_ack_checker.sv
// I2C master ACK/NACK detector: samples SDA during the ninth-bit SCL high phase.
// Optional window timeout is built only when ACK_TIMEOUT_EN is defined.
module i2c_master_ack_checker #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RETRY_MAX      = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    SCL,
    input  logic                    SDA,
    i2c_master_ack_checker_if.slave ctl
);
    localparam int unsigned CntW = $clog2(RETRY_MAX + 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StWaitHigh = 3'd1;
    localparam logic [2:0] StSample   = 3'd2;
    localparam logic [2:0] StWaitLow  = 3'd3;
    localparam logic [2:0] StHold     = 3'd4;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (RETRY_MAX < 1) begin : g_bad_retry
        $error("RETRY_MAX must be at least 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_d_q;
    logic                   scl_rise;
    logic                   scl_fall;

    logic [2:0]      state_q, state_d;
    logic            samp_q, samp_d;
    logic            ack_q, ack_d;
    logic            ack_valid_q, ack_valid_d;
    logic            bus_err_q, bus_err_d;
    logic [CntW-1:0] nack_cnt_q, nack_cnt_d;
    logic            in_window;
    logic            tmo_hit;

    // Synchronizers reset high so an idle bus produces no spurious edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_d_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA};
            scl_d_q    <= scl_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d_q;
    assign scl_fall = ~scl_s & scl_d_q;

    assign in_window = (state_q == StWaitHigh) || (state_q == StSample) ||
                       (state_q == StWaitLow);

`ifdef ACK_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;

    assign tmo_hit = in_window && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == StIdle) begin
            tmo_cnt_d = '0;
        end else if (in_window) begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
    end

    // An abort (enable low) wins over a coincident timeout.
    assign timeout_d = tmo_hit && ctl.enable;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign ctl.timeout = timeout_q;
`else
    assign tmo_hit     = 1'b0;
    assign ctl.timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        ack_d       = ack_q;
        ack_valid_d = 1'b0;
        bus_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ctl.enable) begin
                    state_d = StWaitHigh;
                end
            end
            StWaitHigh: begin
                if (!ctl.enable) begin
                    state_d = StIdle;
                end else if (tmo_hit) begin
                    state_d = StHold;
                end else if (scl_rise) begin
                    samp_d  = sda_s;
                    state_d = StSample;
                end
            end
            StSample: begin
                if (!ctl.enable) begin
                    state_d = StIdle;
                end else if (tmo_hit) begin
                    state_d = StHold;
                end else if (sda_s != samp_q) begin
                    bus_err_d = 1'b1;
                    state_d   = StHold;
                end else if (scl_fall) begin
                    state_d = StWaitLow;
                end
            end
            StWaitLow: begin
                if (!ctl.enable) begin
                    state_d = StIdle;
                end else if (tmo_hit) begin
                    state_d = StHold;
                end else begin
                    ack_d       = ~samp_q;
                    ack_valid_d = 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (!ctl.enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Consecutive-NACK counter; clear_retry overrides a same-cycle NACK.
    always_comb begin
        nack_cnt_d = nack_cnt_q;
        if (ack_valid_d) begin
            if (ack_d) begin
                nack_cnt_d = '0;
            end else if (nack_cnt_q != CntW'(RETRY_MAX)) begin
                nack_cnt_d = nack_cnt_q + CntW'(1);
            end
        end
        if (ctl.clear_retry) begin
            nack_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            samp_q      <= 1'b1;
            ack_q       <= 1'b0;
            ack_valid_q <= 1'b0;
            bus_err_q   <= 1'b0;
            nack_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            ack_q       <= ack_d;
            ack_valid_q <= ack_valid_d;
            bus_err_q   <= bus_err_d;
            nack_cnt_q  <= nack_cnt_d;
        end
    end

    assign ctl.busy       = (state_q != StIdle);
    assign ctl.ack_valid  = ack_valid_q;
    assign ctl.ack        = ack_q;
    assign ctl.bus_err    = bus_err_q;
    assign ctl.nack_cnt   = nack_cnt_q;
    assign ctl.nack_limit = (nack_cnt_q == CntW'(RETRY_MAX));
endmodule

// File: tb/tb_i2c_master_ack_checker.sv
// Scoreboard bench for i2c_master_ack_checker: directed windows push expected
// results; a negedge monitor pops and compares on every result pulse.
module tb_i2c_master_ack_checker;
    localparam int unsigned SyncStages    = 2;
    localparam int unsigned TimeoutCycles = 16;
    localparam int unsigned RetryMax      = 3;

    typedef struct {
        int kind;  // 0 = ack_valid, 1 = bus_err, 2 = timeout
        int ack;
        int cnt;
        int lim;
        int cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl   = 1'b0;
    logic sda   = 1'b1;

    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;
    int   exp_ack  = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   mon_kind;

    i2c_master_ack_checker_if #(.RETRY_MAX(RetryMax)) ctl_if ();

    i2c_master_ack_checker #(
        .SYNC_STAGES   (SyncStages),
        .TIMEOUT_CYCLES(TimeoutCycles),
        .RETRY_MAX     (RetryMax)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .SCL(scl),
        .SDA(sda),
        .ctl(ctl_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model of one ACK/NACK result, including the saturating counter.
    task automatic expect_result(input logic sda_v, input bit clr, input int at);
        exp_t e;
        if (!sda_v) begin
            exp_cnt = 0;
        end else if (exp_cnt < int'(RetryMax)) begin
            exp_cnt = exp_cnt + 1;
        end
        if (clr) exp_cnt = 0;
        exp_ack = sda_v ? 0 : 1;
        e.kind = 0;
        e.ack  = exp_ack;
        e.cnt  = exp_cnt;
        e.lim  = (exp_cnt == int'(RetryMax)) ? 1 : 0;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic expect_pulse(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.ack  = 0;
        e.cnt  = 0;
        e.lim  = 0;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic run_window(input logic sda_v, input bit clr);
        int k;
        sda = sda_v;
        ctl_if.enable = 1'b1;
        step(4);
        check("busy_in_window", int'(ctl_if.busy), 1);
        scl = 1'b1;
        step(6);
        scl = 1'b0;
        k = cyc;
        expect_result(sda_v, clr, k + int'(SyncStages) + 2);
        step(int'(SyncStages) + 1);
        ctl_if.clear_retry = clr;
        step(1);
        ctl_if.clear_retry = 1'b0;
        step(3);
        check("busy_in_hold", int'(ctl_if.busy), 1);
        ctl_if.enable = 1'b0;
        step(2);
        check("busy_after_release", int'(ctl_if.busy), 0);
        sda = 1'b1;
    endtask

    always @(negedge clk) begin
        if (ctl_if.ack_valid || ctl_if.bus_err || ctl_if.timeout) begin
            mon_kind = ctl_if.ack_valid ? 0 : (ctl_if.bus_err ? 1 : 2);
            check("pulse_exclusive",
                  int'(ctl_if.ack_valid) + int'(ctl_if.bus_err) + int'(ctl_if.timeout), 1);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required none",
                         mon_kind, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", mon_kind, mon_e.kind);
                check("pulse_cycle", cyc, mon_e.cyc);
                if (mon_e.kind == 0) begin
                    check("ack", int'(ctl_if.ack), mon_e.ack);
                    check("nack_cnt", int'(ctl_if.nack_cnt), mon_e.cnt);
                    check("nack_limit", int'(ctl_if.nack_limit), mon_e.lim);
                end
            end
        end
    end

    initial begin
        int k;
        ctl_if.enable      = 1'b0;
        ctl_if.clear_retry = 1'b0;
        step(3);
        check("rst_busy", int'(ctl_if.busy), 0);
        check("rst_ack_valid", int'(ctl_if.ack_valid), 0);
        check("rst_ack", int'(ctl_if.ack), 0);
        check("rst_bus_err", int'(ctl_if.bus_err), 0);
        check("rst_timeout", int'(ctl_if.timeout), 0);
        check("rst_nack_cnt", int'(ctl_if.nack_cnt), 0);
        check("rst_nack_limit", int'(ctl_if.nack_limit), 0);
        rst_n = 1'b1;
        step(4);

        run_window(1'b0, 1'b0);                 // ACK
        for (int i = 0; i < 4; i++) begin
            run_window(1'b1, 1'b0);             // NACK 1,2,3, then saturate at 3
        end
        run_window(1'b0, 1'b0);                 // ACK clears the count
        run_window(1'b1, 1'b0);
        run_window(1'b1, 1'b0);                 // count now 2
        run_window(1'b1, 1'b1);                 // clear_retry wins over NACK

        // SDA rises while SCL is high: bus error, then hold until enable drops.
        sda = 1'b0;
        ctl_if.enable = 1'b1;
        step(4);
        scl = 1'b1;
        step(6);
        sda = 1'b1;
        expect_pulse(1, cyc + int'(SyncStages) + 1);
        step(3);
        scl = 1'b0;
        step(6);
        check("busy_hold_after_bus_err", int'(ctl_if.busy), 1);
        check("ack_held_after_bus_err", int'(ctl_if.ack), exp_ack);
        ctl_if.enable = 1'b0;
        step(1);
        check("busy_idle_after_bus_err", int'(ctl_if.busy), 0);
        step(2);

        // Abort during SAMPLE: no pulse, counter untouched.
        run_window(1'b1, 1'b0);                 // count 1 so abort/reset are visible
        sda = 1'b0;
        ctl_if.enable = 1'b1;
        step(4);
        scl = 1'b1;
        step(5);
        ctl_if.enable = 1'b0;
        step(1);
        check("busy_after_abort", int'(ctl_if.busy), 0);
        step(2);
        scl = 1'b0;
        step(8);
        check("nack_cnt_after_abort", int'(ctl_if.nack_cnt), exp_cnt);
        sda = 1'b1;

        // Reset asserted while in WAIT_LOW.
        ctl_if.enable = 1'b1;
        step(4);
        scl = 1'b1;
        step(6);
        scl = 1'b0;
        k = cyc;
        step(int'(SyncStages) + 1);
        check("busy_before_reset", int'(ctl_if.busy), 1);
        check("nack_cnt_before_reset", int'(ctl_if.nack_cnt), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(ctl_if.busy), 0);
        check("mid_rst_ack_valid", int'(ctl_if.ack_valid), 0);
        check("mid_rst_nack_cnt", int'(ctl_if.nack_cnt), 0);
        check("mid_rst_nack_limit", int'(ctl_if.nack_limit), 0);
        exp_cnt = 0;
        exp_ack = 0;
        ctl_if.enable = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(5);
        check("idle_after_reset", int'(ctl_if.busy), 0);

        // SCL stuck low: timeout only when the feature is built.
        ctl_if.enable = 1'b1;
`ifdef ACK_TIMEOUT_EN
        expect_pulse(2, cyc + 1 + int'(TimeoutCycles));
`endif
        step(int'(TimeoutCycles) + 10);
        check("busy_scl_stuck", int'(ctl_if.busy), 1);
        check("nack_cnt_after_stuck", int'(ctl_if.nack_cnt), exp_cnt);
        ctl_if.enable = 1'b0;
        step(4);

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_master_ack_checker.md
# i2c_master_ack_checker

Master-side acknowledgement detector for the I2C bus. It runs on the system clock, oversamples the bus SCL/SDA lines, and during the ninth-bit window samples SDA on the SCL high phase to classify the slave response as ACK (SDA low) or NACK (SDA high). It sits between the master byte transmitter, which opens the window after releasing SDA, and the master control FSM, which consumes the result and uses the consecutive-NACK count for retry decisions.

## Interface
- SYNC_STAGES, 2, synchronizer depth for SCL and SDA (minimum 2).
- TIMEOUT_CYCLES, 1024, CLK cycles allowed per window before timeout (used only with ACK_TIMEOUT_EN).
- RETRY_MAX, 3, consecutive-NACK count that asserts nack_limit (minimum 1).
- CLK  in  1  system clock; SCL/SDA are sampled on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- SCL  in  1  bus clock as seen on the wire; asynchronous to CLK.
- SDA  in  1  bus data as seen on the wire; asynchronous to CLK.
- enable  in  1  high while the transmitter holds SDA released for the ACK bit.
- clear_retry  in  1  synchronous clear of the NACK counter.
- busy  out  1  high in every state except IDLE.
- ack_valid  out  1  one-cycle pulse: result is available.
- ack  out  1  held result: 1 = ACK, 0 = NACK; valid from the ack_valid pulse until the next ack_valid.
- bus_err  out  1  one-cycle pulse: SDA toggled while SCL was high inside the window.
- timeout  out  1  one-cycle pulse: the window exceeded TIMEOUT_CYCLES.
- nack_cnt  out  $clog2(RETRY_MAX+1)  consecutive NACKs, saturating at RETRY_MAX.
- nack_limit  out  1  high while nack_cnt == RETRY_MAX.

## Operation
- SCL and SDA pass through SYNC_STAGES flops each; the synced values are scl_s and sda_s. A one-flop delay of scl_s provides rise/fall detection.
- FSM states: IDLE, WAIT_HIGH, SAMPLE, WAIT_LOW, HOLD.
- IDLE: enable=1 → WAIT_HIGH. No edge qualification is applied in IDLE.
- WAIT_HIGH: on scl_s rise, latch sda_s into samp and go to SAMPLE.
- SAMPLE (SCL high): if sda_s != samp → bus_err pulse, go to HOLD, no ack_valid. On scl_s fall → WAIT_LOW.
- WAIT_LOW: ack <= ~samp, ack_valid pulse, go to HOLD. The result registers on the first CLK cycle after the fall is detected.
- HOLD: wait for enable=0 → IDLE. This prevents re-triggering from a single long enable.
- enable=0 in WAIT_HIGH, SAMPLE, or WAIT_LOW aborts the window: go to IDLE, with no ack_valid, bus_err, or counter change.
- NACK counter:
  - ACK result → 0.
  - NACK result → +1, saturating at RETRY_MAX.
  - clear_retry → 0. It has priority over a simultaneous NACK result in the same cycle.
  - bus_err and timeout do not change the counter.
- Reset values: FSM=IDLE; synchronizer flops=1 (bus idle high); samp=1; ack=0; ack_valid=0; bus_err=0; timeout=0; nack_cnt=0; nack_limit=0; busy=0.

## Timing
- Latency from a wire SCL rise to the SDA sample: SYNC_STAGES+1 CLK cycles.
- Latency from a wire SCL fall to ack_valid: SYNC_STAGES+2 CLK cycles.
- SDA must be stable from SYNC_STAGES CLK cycles before the wire SCL rise until the wire SCL fall. This matches the I2C rule that data is stable while SCL is high.
- ack_valid, bus_err, and timeout are each exactly one CLK wide and mutually exclusive per window.
- nack_cnt and nack_limit update on the same edge that raises ack_valid.
- An asynchronous RST assertion mid-window returns all outputs to their reset values immediately. After RST deassertion, a new window starts only when enable is seen high in IDLE.
- If SCL is already high when enable rises, the FSM waits for the next rise. A partial high phase is never sampled.

## Configuration
- ACK_TIMEOUT_EN defined:
  - A $clog2(TIMEOUT_CYCLES)-bit counter clears on entry to WAIT_HIGH.
  - It increments every CLK cycle in WAIT_HIGH, SAMPLE, and WAIT_LOW.
  - At TIMEOUT_CYCLES-1 it raises a timeout pulse, the FSM goes to HOLD, and no ack_valid is issued. This catches a stuck or stretched SCL.
- ACK_TIMEOUT_EN undefined: no counter is built, timeout is tied to 0, and the FSM waits indefinitely for SCL edges.

## Test plan
- ACK: enable=1, SDA=0 across one SCL high pulse → ack_valid pulse SYNC_STAGES+2 cycles after the fall, ack=1, nack_cnt=0.
- NACK retry: three windows with SDA=1 (RETRY_MAX=3) → ack=0 each time, nack_cnt steps 1,2,3, nack_limit=1 after the third. A fourth NACK leaves nack_cnt=3. A following ACK returns nack_cnt to 0.
- Bus error: SDA 0→1 while SCL is high in the window → single bus_err pulse, no ack_valid, FSM in HOLD until enable=0.
- Abort/reset: enable dropped during SAMPLE → IDLE with no pulse. RST pulled low during WAIT_LOW → all outputs 0, busy=0.
- Timeout (ACK_TIMEOUT_EN, TIMEOUT_CYCLES=16): enable=1 with SCL held low → timeout pulse 16 cycles after window entry, no ack_valid. With the macro undefined, no pulse ever occurs.
- clear_retry asserted on the same cycle as a NACK result with nack_cnt=2 → nack_cnt=0.
